alu_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single RV32I ALU between the execute path (requester 0) and the address/branch-compare path (requester 1). It accepts operations over valid/ready handshakes, grants round-robin, and registers the operands into an issue stage. It holds each result in a per-requester response buffer until that requester takes it. It sits between the decode/execute control logic and one `ALU` instance.

---
 rtl/alu_pkg.sv | 16 +
 rtl/ALU.sv | 27 ++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared RV32I ALU opcode encoding and the last legal opcode value.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;
    localparam logic [3:0] ALU_OP_LAST = 4'd9;
endpackage

// File: rtl/ALU.sv
// ALU: combinational RV32I ALU; opcodes above ALU_OP_LAST yield zero.
// Ports: i_op_a, i_op_b (32, shifts use i_op_b[4:0]), i_alu_op (4), o_alu_data (32).
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [3:0]  i_alu_op,
    output logic [31:0] o_alu_data
);
    always_comb begin
        o_alu_data = 32'h0;
        case (i_alu_op)
            ALU_ADD:  o_alu_data = i_op_a + i_op_b;
            ALU_SUB:  o_alu_data = i_op_a - i_op_b;
            ALU_SLT:  o_alu_data = {31'b0, $signed(i_op_a) < $signed(i_op_b)};
            ALU_SLTU: o_alu_data = {31'b0, i_op_a < i_op_b};
            ALU_XOR:  o_alu_data = i_op_a ^ i_op_b;
            ALU_OR:   o_alu_data = i_op_a | i_op_b;
            ALU_AND:  o_alu_data = i_op_a & i_op_b;
            ALU_SLL:  o_alu_data = i_op_a << i_op_b[4:0];
            ALU_SRL:  o_alu_data = i_op_a >> i_op_b[4:0];
            ALU_SRA:  o_alu_data = $unsigned($signed(i_op_a) >>> i_op_b[4:0]);
            default:  o_alu_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters,
// with a single issue stage and one registered response buffer per requester.
// Ports: i_clk/i_rst (sync, active-high); i_reqN_* / o_reqN_ready request
// handshake with operands, opcode and tag; o_rspN_* / i_rspN_ready response
// handshake with data, tag and illegal-opcode flag; o_busy any entry in flight.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic             i_req1_valid,
    output logic             o_req0_ready,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req0_op_a,
    input  logic [31:0]      i_req1_op_a,
    input  logic [31:0]      i_req0_op_b,
    input  logic [31:0]      i_req1_op_b,
    input  logic [3:0]       i_req0_alu_op,
    input  logic [3:0]       i_req1_alu_op,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp0_valid,
    output logic             o_rsp1_valid,
    input  logic             i_rsp0_ready,
    input  logic             i_rsp1_ready,
    output logic [31:0]      o_rsp0_data,
    output logic [31:0]      o_rsp1_data,
    output logic [TAG_W-1:0] o_rsp0_tag,
    output logic [TAG_W-1:0] o_rsp1_tag,
    output logic             o_rsp0_err,
    output logic             o_rsp1_err,
    output logic             o_busy
);
    logic             rr;
    logic             iss_valid;
    logic             iss_owner;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;
    logic [3:0]       iss_op;
    logic [TAG_W-1:0] iss_tag;
    logic [31:0]      alu_data;
    logic             pop0, pop1, advance, slot_free, sel0, sel1, grant, illegal;

    ALU u_alu (
        .i_op_a    (iss_a),
        .i_op_b    (iss_b),
        .i_alu_op  (iss_op),
        .o_alu_data(alu_data)
    );

    assign pop0      = o_rsp0_valid & i_rsp0_ready;
    assign pop1      = o_rsp1_valid & i_rsp1_ready;
    // A buffer being popped this cycle can take the next result on the same edge.
    assign advance   = iss_valid & (iss_owner ? (~o_rsp1_valid | pop1) : (~o_rsp0_valid | pop0));
    assign slot_free = ~iss_valid | advance;
    assign sel0      = i_req0_valid & (~i_req1_valid | ~rr);
    assign sel1      = i_req1_valid & (~i_req0_valid | rr);
    assign o_req0_ready = ~i_rst & slot_free & sel0;
    assign o_req1_ready = ~i_rst & slot_free & sel1;
    assign grant     = o_req0_ready | o_req1_ready;
    assign illegal   = iss_op > ALU_OP_LAST;
    assign o_busy    = iss_valid | o_rsp0_valid | o_rsp1_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr           <= 1'b0;
            iss_valid    <= 1'b0;
            iss_owner    <= 1'b0;
            iss_a        <= '0;
            iss_b        <= '0;
            iss_op       <= '0;
            iss_tag      <= '0;
            o_rsp0_valid <= 1'b0;
            o_rsp0_data  <= '0;
            o_rsp0_tag   <= '0;
            o_rsp0_err   <= 1'b0;
            o_rsp1_valid <= 1'b0;
            o_rsp1_data  <= '0;
            o_rsp1_tag   <= '0;
            o_rsp1_err   <= 1'b0;
        end else begin
            if (grant) begin
                // Priority passes to whichever requester was not granted.
                rr        <= o_req0_ready;
                iss_valid <= 1'b1;
                iss_owner <= o_req1_ready;
                iss_a     <= o_req1_ready ? i_req1_op_a : i_req0_op_a;
                iss_b     <= o_req1_ready ? i_req1_op_b : i_req0_op_b;
                iss_op    <= o_req1_ready ? i_req1_alu_op : i_req0_alu_op;
                iss_tag   <= o_req1_ready ? i_req1_tag : i_req0_tag;
            end else if (advance) begin
                iss_valid <= 1'b0;
            end
            if (advance && !iss_owner) begin
                o_rsp0_valid <= 1'b1;
                o_rsp0_data  <= alu_data;
                o_rsp0_tag   <= iss_tag;
                o_rsp0_err   <= illegal;
            end else if (pop0) begin
                o_rsp0_valid <= 1'b0;
            end
            if (advance && iss_owner) begin
                o_rsp1_valid <= 1'b1;
                o_rsp1_data  <= alu_data;
                o_rsp1_tag   <= iss_tag;
                o_rsp1_err   <= illegal;
            end else if (pop1) begin
                o_rsp1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_op_a, i_req1_op_a, i_req0_op_b, i_req1_op_b;
    logic [3:0]  i_req0_alu_op, i_req1_alu_op;
    logic [3:0]  i_req0_tag, i_req1_tag;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic        i_rsp0_ready, i_rsp1_ready;
    logic [31:0] o_rsp0_data, o_rsp1_data;
    logic [3:0]  o_rsp0_tag, o_rsp1_tag;
    logic        o_rsp0_err, o_rsp1_err;
    logic        o_busy;
    int          checks = 0;
    int          errors = 0;

    alu_arbiter #(.TAG_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .i_req0_op_a(i_req0_op_a), .i_req1_op_a(i_req1_op_a),
        .i_req0_op_b(i_req0_op_b), .i_req1_op_b(i_req1_op_b),
        .i_req0_alu_op(i_req0_alu_op), .i_req1_alu_op(i_req1_alu_op),
        .i_req0_tag(i_req0_tag), .i_req1_tag(i_req1_tag),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
        .i_rsp0_ready(i_rsp0_ready), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp0_data(o_rsp0_data), .o_rsp1_data(o_rsp1_data),
        .o_rsp0_tag(o_rsp0_tag), .o_rsp1_tag(o_rsp1_tag),
        .o_rsp0_err(o_rsp0_err), .o_rsp1_err(o_rsp1_err),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        i_req0_valid = v; i_req0_op_a = a; i_req0_op_b = b; i_req0_alu_op = op; i_req0_tag = tag;
        #1;
    endtask

    task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        i_req1_valid = v; i_req1_op_a = a; i_req1_op_b = b; i_req1_alu_op = op; i_req1_tag = tag;
        #1;
    endtask

    task automatic rsp0(input logic [31:0] v, input logic [31:0] d, input logic [31:0] t,
                        input logic [31:0] e, input string tag);
        chk({tag, ".v0"}, 32'(o_rsp0_valid), v);
        if (v[0]) begin
            chk({tag, ".d0"}, o_rsp0_data, d);
            chk({tag, ".t0"}, 32'(o_rsp0_tag), t);
            chk({tag, ".e0"}, 32'(o_rsp0_err), e);
        end
    endtask

    task automatic rsp1(input logic [31:0] v, input logic [31:0] d, input logic [31:0] t,
                        input logic [31:0] e, input string tag);
        chk({tag, ".v1"}, 32'(o_rsp1_valid), v);
        if (v[0]) begin
            chk({tag, ".d1"}, o_rsp1_data, d);
            chk({tag, ".t1"}, 32'(o_rsp1_tag), t);
            chk({tag, ".e1"}, 32'(o_rsp1_err), e);
        end
    endtask

    task automatic rdy(input logic [31:0] r0, input logic [31:0] r1, input string tag);
        chk({tag, ".rdy0"}, 32'(o_req0_ready), r0);
        chk({tag, ".rdy1"}, 32'(o_req1_ready), r1);
    endtask

    initial begin
        i_rst = 1'b1;
        i_rsp0_ready = 1'b0;
        i_rsp1_ready = 1'b0;
        req0(1'b1, 32'd0, 32'd0, 4'd0, 4'd0);
        req1(1'b1, 32'd0, 32'd0, 4'd0, 4'd0);
        tick();
        tick();
        // Reset state
        rdy(0, 0, "rst");
        chk("rst.v0", 32'(o_rsp0_valid), 0);
        chk("rst.v1", 32'(o_rsp1_valid), 0);
        chk("rst.d0", o_rsp0_data, 0);
        chk("rst.d1", o_rsp1_data, 0);
        chk("rst.t0", 32'(o_rsp0_tag), 0);
        chk("rst.e1", 32'(o_rsp1_err), 0);
        chk("rst.busy", 32'(o_busy), 0);
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        req1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        i_rst = 1'b0;
        tick();

        // Single op: ADD 5+7 tag 3
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        req0(1'b1, 32'd5, 32'd7, 4'd0, 4'd3);
        rdy(1, 0, "single");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp0(0, 0, 0, 0, "single.t1");
        chk("single.busy", 32'(o_busy), 1);
        tick();
        rsp0(1, 32'd12, 3, 0, "single.t2");
        tick();
        rsp0(0, 0, 0, 0, "single.t3");
        chk("single.idle", 32'(o_busy), 0);

        // Round robin; last grant went to req0 so req1 has priority now
        req0(1'b1, 32'hFFFFFFFF, 32'd1, 4'd2, 4'd1);
        req1(1'b1, 32'd1, 32'd2, 4'd1, 4'd2);
        rdy(0, 1, "rr.a");
        tick();
        req1(1'b1, 32'd10, 32'd20, 4'd0, 4'd4);
        rdy(1, 0, "rr.b");
        tick();
        rsp1(1, 32'hFFFFFFFF, 2, 0, "rr.sub");
        req0(1'b1, 32'hFFFFFFFF, 32'd1, 4'd3, 4'd5);
        rdy(0, 1, "rr.c");
        tick();
        rsp0(1, 32'd1, 1, 0, "rr.slt");
        rsp1(0, 0, 0, 0, "rr.c1");
        req1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rdy(1, 0, "rr.d");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp1(1, 32'd30, 4, 0, "rr.add");
        rsp0(0, 0, 0, 0, "rr.d0");
        tick();
        rsp0(1, 32'd0, 5, 0, "rr.sltu");
        tick();
        chk("rr.idle", 32'(o_busy), 0);

        // Backpressure on requester 1 (rr now favours req1)
        i_rsp1_ready = 1'b0;
        req1(1'b1, 32'd1, 32'd1, 4'd0, 4'd1);
        rdy(0, 1, "bp.1");
        tick();
        req1(1'b1, 32'd2, 32'd2, 4'd0, 4'd2);
        rdy(0, 1, "bp.2");
        tick();
        req1(1'b1, 32'd3, 32'd3, 4'd0, 4'd3);
        req0(1'b1, 32'h0000F0F0, 32'h0000FF00, 4'd4, 4'd7);
        rdy(0, 0, "bp.stall1");
        rsp1(1, 32'd2, 1, 0, "bp.r1");
        tick();
        rdy(0, 0, "bp.stall2");
        rsp1(1, 32'd2, 1, 0, "bp.hold");
        i_rsp1_ready = 1'b1;
        #1;
        rdy(1, 0, "bp.release");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp1(1, 32'd4, 2, 0, "bp.r2");
        rdy(0, 1, "bp.third");
        tick();
        req1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp0(1, 32'h00000FF0, 7, 0, "bp.xor");
        rsp1(0, 0, 0, 0, "bp.gap");
        tick();
        rsp1(1, 32'd6, 3, 0, "bp.r3");
        tick();
        chk("bp.idle", 32'(o_busy), 0);

        // Shifts and illegal opcode, back to back on req0
        req0(1'b1, 32'h80000000, 32'd31, 4'd9, 4'd1);
        rdy(1, 0, "sh.0");
        tick();
        req0(1'b1, 32'h80000000, 32'd31, 4'd8, 4'd2);
        rdy(1, 0, "sh.1");
        tick();
        req0(1'b1, 32'd1, 32'h21, 4'd7, 4'd3);
        rdy(1, 0, "sh.2");
        rsp0(1, 32'hFFFFFFFF, 1, 0, "sh.sra");
        tick();
        req0(1'b1, 32'd9, 32'd9, 4'd12, 4'd4);
        rdy(1, 0, "sh.3");
        rsp0(1, 32'd1, 2, 0, "sh.srl");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp0(1, 32'd2, 3, 0, "sh.sll");
        tick();
        rsp0(1, 32'd0, 4, 1, "sh.ill");
        tick();
        chk("sh.idle", 32'(o_busy), 0);

        // Simultaneous pop and load on buffer 0
        i_rsp0_ready = 1'b0;
        req0(1'b1, 32'd1, 32'd2, 4'd0, 4'd1);
        tick();
        req0(1'b1, 32'd3, 32'd4, 4'd0, 4'd2);
        rdy(1, 0, "pl.acc2");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        rsp0(1, 32'd3, 1, 0, "pl.first");
        i_rsp0_ready = 1'b1;
        tick();
        rsp0(1, 32'd7, 2, 0, "pl.second");
        tick();
        rsp0(0, 0, 0, 0, "pl.empty");

        // Fill issue stage and both buffers, then reset mid-flight
        i_rsp0_ready = 1'b0;
        i_rsp1_ready = 1'b0;
        req0(1'b1, 32'd1, 32'd1, 4'd0, 4'd1);
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        req1(1'b1, 32'd2, 32'd2, 4'd0, 4'd2);
        rdy(0, 1, "mr.req1");
        tick();
        req1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        req0(1'b1, 32'd3, 32'd3, 4'd0, 4'd3);
        rdy(1, 0, "mr.req0");
        tick();
        rsp0(1, 32'd2, 1, 0, "mr.full0");
        rsp1(1, 32'd4, 2, 0, "mr.full1");
        req1(1'b1, 32'd4, 32'd4, 4'd0, 4'd4);
        rdy(0, 0, "mr.stall");
        i_rst = 1'b1;
        #1;
        rdy(0, 0, "mr.inrst");
        tick();
        i_rst = 1'b0;
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        req0(1'b1, 32'd8, 32'd9, 4'd0, 4'd6);
        rsp0(0, 0, 0, 0, "mr.post0");
        rsp1(0, 0, 0, 0, "mr.post1");
        chk("mr.busy", 32'(o_busy), 0);
        rdy(1, 0, "mr.grant");
        tick();
        req0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        req1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
        tick();
        rsp0(1, 32'd17, 6, 0, "mr.result");
        rsp1(0, 0, 0, 0, "mr.none1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
